// File: rtl/train_seq_ctrl.sv
// Top-level training/inference sequencer: walks FF -> FB x BATCH_SIZE -> LB -> UPDATE
// per iteration, kicking each stage unit with stage_start and advancing on stage_done.
module train_seq_ctrl #(
  parameter int BATCH_SIZE = 32,
  parameter int CNT_W      = 8,
  parameter int STATE_LEN  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [CNT_W-1:0]     num_iter,
  input  logic                 stage_done,
  input  logic                 abort,
  output logic [STATE_LEN-1:0] q,
  output logic                 stage_start,
  output logic [CNT_W-1:0]     batch_idx,
  output logic [CNT_W-1:0]     iter_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted
);

  localparam logic [STATE_LEN-1:0] S_IDLE   = STATE_LEN'(0);
  localparam logic [STATE_LEN-1:0] S_FF     = STATE_LEN'(1);
  localparam logic [STATE_LEN-1:0] S_FB     = STATE_LEN'(2);
  localparam logic [STATE_LEN-1:0] S_LB     = STATE_LEN'(3);
  localparam logic [STATE_LEN-1:0] S_UPDATE = STATE_LEN'(4);
  localparam logic [STATE_LEN-1:0] S_FIN    = STATE_LEN'(5);

  localparam logic [1:0]       M_TRAIN    = 2'b01;
  localparam logic [1:0]       M_GRAD     = 2'b10;
  localparam logic [CNT_W-1:0] BATCH_LAST = CNT_W'(BATCH_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [1:0]           mode_r;
  logic [CNT_W-1:0]     num_iter_r;
  logic [STATE_LEN-1:0] q_nxt;
  logic [CNT_W-1:0]     batch_nxt;
  logic [CNT_W-1:0]     iter_nxt;
  logic                 kick_nxt;
  logic                 aborted_nxt;
  logic                 latch_run;
  logic                 iter_end;
  logic                 pass_done;
  logic                 is_train;
  logic                 is_grad;
  logic                 iter_last;

  // A stage_done in the kick cycle belongs to the previous pass, so it is ignored.
  assign pass_done = stage_done && !stage_start;
  assign is_train  = (mode_r == M_TRAIN);
  assign is_grad   = (mode_r == M_GRAD);
  assign iter_last = (iter_idx == num_iter_r - CNT_ONE);

  assign busy = (q != S_IDLE);
  assign done = (q == S_FIN);

  always_comb begin
    q_nxt       = q;
    batch_nxt   = batch_idx;
    iter_nxt    = iter_idx;
    kick_nxt    = 1'b0;
    aborted_nxt = aborted;
    latch_run   = 1'b0;
    iter_end    = 1'b0;
    case (q)
      S_IDLE: begin
        if (start) begin
          latch_run   = 1'b1;
          q_nxt       = S_FF;
          batch_nxt   = '0;
          iter_nxt    = '0;
          aborted_nxt = 1'b0;
          kick_nxt    = 1'b1;
        end
      end
      S_FF, S_FB, S_LB, S_UPDATE: begin
        if (abort) begin
          q_nxt       = S_FIN;
          aborted_nxt = 1'b1;
        end else if (pass_done) begin
          case (q)
            S_FF: begin
              if (is_train || is_grad) begin
                q_nxt    = S_FB;
                kick_nxt = 1'b1;
              end else begin
                q_nxt = S_FIN;
              end
            end
            S_FB: begin
              kick_nxt = 1'b1;
              if (batch_idx != BATCH_LAST) begin
                batch_nxt = batch_idx + CNT_ONE;
              end else begin
                q_nxt = S_LB;
              end
            end
            S_LB: begin
              if (is_train) begin
                q_nxt    = S_UPDATE;
                kick_nxt = 1'b1;
              end else begin
                iter_end = 1'b1;
              end
            end
            default: iter_end = 1'b1;
          endcase
        end
      end
      S_FIN: q_nxt = S_IDLE;
      default: begin
        q_nxt       = S_IDLE;
        batch_nxt   = '0;
        iter_nxt    = '0;
        aborted_nxt = 1'b0;
      end
    endcase

    if (iter_end) begin
      if (iter_last) begin
        q_nxt = S_FIN;
      end else begin
        q_nxt     = S_FF;
        iter_nxt  = iter_idx + CNT_ONE;
        batch_nxt = '0;
        kick_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q           <= S_IDLE;
      stage_start <= 1'b0;
      batch_idx   <= '0;
      iter_idx    <= '0;
      aborted     <= 1'b0;
      mode_r      <= '0;
      num_iter_r  <= '0;
    end else begin
      q           <= q_nxt;
      stage_start <= kick_nxt;
      batch_idx   <= batch_nxt;
      iter_idx    <= iter_nxt;
      aborted     <= aborted_nxt;
      if (latch_run) begin
        mode_r     <= mode;
        num_iter_r <= (num_iter == '0) ? CNT_ONE : num_iter;
      end
    end
  end

endmodule

// File: doc/train_seq_ctrl.md
Name: train_seq_ctrl

Overview:
Parametrised main sequencer for the training/inference datapath. It supersedes the free-running main state machine, which advanced one state per `run` cycle. This block instead drives each stage unit with a start/done handshake and counts batch samples and update iterations. It supports three run modes and an abort path. It sits at the top of the train state-machine hierarchy and feeds the sub-state machines of each stage.

Parameters:
BATCH_SIZE, 32, number of FB passes per iteration (≥1)
CNT_W, 8, width of num_iter, iter_idx and batch_idx; must hold BATCH_SIZE-1 and num_iter-1
STATE_LEN, 3, width of state output q

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request a run; accepted only in IDLE
mode  in  2  00 INFER, 01 TRAIN, 10 GRAD (no UPDATE), 11 treated as INFER
num_iter  in  CNT_W  iterations per run; 0 treated as 1
stage_done  in  1  single-cycle completion pulse from the active stage unit
abort  in  1  terminate the current run
q  out  STATE_LEN  current state: IDLE=0, FF=1, FB=2, LB=3, UPDATE=4, FIN=5
stage_start  out  1  one-cycle kick to the stage unit selected by q
batch_idx  out  CNT_W  current FB sample index
iter_idx  out  CNT_W  current iteration index
busy  out  1  high whenever q != IDLE
done  out  1  one-cycle pulse, high while in FIN
aborted  out  1  last run ended by abort; held until next accepted start

Behaviour:
- Reset: q=IDLE, and stage_start, batch_idx, iter_idx, busy, done, aborted all 0. Latched mode and num_iter cleared.
- IDLE:
  - start=1 latches mode and num_iter (0 → 1), clears batch_idx, iter_idx and aborted, and sets q←FF.
  - Later mode/num_iter changes have no effect until the next start.
- Work states (FF, FB, LB, UPDATE):
  - stage_start=1 for exactly the first cycle of each pass. A pass starts on every entry to a state and on every FB repetition.
  - stage_done is ignored in a cycle where stage_start=1. Minimum pass length is therefore 2 cycles.
  - q holds until a valid stage_done arrives.
- Transitions on valid stage_done:
  - FF: INFER → FIN; TRAIN/GRAD → FB.
  - FB: if batch_idx != BATCH_SIZE-1, batch_idx++, stay in FB and re-pulse stage_start the next cycle. Otherwise → LB, with batch_idx held at BATCH_SIZE-1.
  - LB: TRAIN → UPDATE; GRAD → iteration-end check.
  - UPDATE → iteration-end check.
  - Iteration-end check: if iter_idx == num_iter-1 → FIN. Otherwise iter_idx++, batch_idx←0, → FF.
- FIN: lasts one cycle with done=1, then → IDLE. start during FIN is ignored.
- Abort:
  - abort=1 in any work state → FIN next cycle and aborted←1. No stage_start is issued.
  - abort beats a simultaneous stage_done.
  - abort in IDLE or FIN is ignored.
- start while busy is ignored (no queuing).
- Illegal q encoding → IDLE next cycle with all outputs cleared.
- Counters never wrap. Both are bounded by the parameter and the latched num_iter.
- Reset mid-run returns to IDLE immediately (asynchronous). A stage_done pending at that moment is lost.

Test Plan:
- INFER, stage_done 2 cycles after each stage_start: q = IDLE→FF→FIN→IDLE, one stage_start, done pulses once, iter_idx=0.
- TRAIN, BATCH_SIZE=4, num_iter=2:
  - Visit order per iteration: FF, FB×4, LB, UPDATE.
  - 14 stage_start pulses in total; batch_idx 0..3 in each iteration; iter_idx 0 then 1.
  - done pulses once.
- GRAD, num_iter=0: behaves as 1 iteration; UPDATE never entered; FIN after LB.
- TRAIN, abort asserted in the same cycle as stage_done at FB batch_idx=2: next q=FIN, aborted=1, then IDLE. aborted clears on the next start.
- start pulsed at FB, and mode toggled mid-run: no restart, and the sequence follows the latched mode. stage_done coincident with stage_start is ignored (q unchanged).
- rst_n asserted in UPDATE with iter_idx=1: outputs reset asynchronously. After release, a new start runs from iter_idx=0.
